// File: rtl/sap2_pkg.sv
// Shared definitions for the SAP-2 arithmetic core: ALU opcodes, flag bit
// positions and the default datapath width.
package sap2_pkg;

  localparam int DEF_DATA_W = 8;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_CMA   = 4'b0101;
  localparam logic [3:0] ALU_RAL   = 4'b0110;
  localparam logic [3:0] ALU_RAR   = 4'b0111;
  localparam logic [3:0] ALU_INC   = 4'b1000;
  localparam logic [3:0] ALU_DEC   = 4'b1001;
  localparam logic [3:0] ALU_PASSA = 4'b1010;
  localparam logic [3:0] ALU_PASST = 4'b1011;

  localparam int FLAG_S = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/sap2_alu.sv
// Purely combinational SAP-2 ALU: R = f(A, T, Sel) with sign and zero
// indications derived from R. All arithmetic wraps modulo 2^W.
module sap2_alu
  import sap2_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] t_i,
  input  logic [3:0]   sel_i,
  output logic [W-1:0] r_o,
  output logic         s_o,
  output logic         z_o
);

  localparam logic [W-1:0] ONE = W'(1);

  always_comb begin
    // NOTE: r_o gets a default before the case so no select value can leave it
    // unassigned and infer a latch.
    r_o = '0;
    case (sel_i)
      ALU_ADD:   r_o = a_i + t_i;
      ALU_SUB:   r_o = a_i - t_i;
      ALU_AND:   r_o = a_i & t_i;
      ALU_OR:    r_o = a_i | t_i;
      ALU_XOR:   r_o = a_i ^ t_i;
      ALU_CMA:   r_o = ~a_i;
      ALU_RAL:   r_o = {a_i[W-2:0], a_i[W-1]};
      ALU_RAR:   r_o = {a_i[0], a_i[W-1:1]};
      ALU_INC:   r_o = t_i + ONE;
      ALU_DEC:   r_o = t_i - ONE;
      ALU_PASSA: r_o = a_i;
      ALU_PASST: r_o = t_i;
      default:   r_o = '0;
    endcase
  end

  assign s_o = r_o[W-1];
  assign z_o = (r_o == '0);

endmodule

// File: rtl/sap2_acc_alu_breg.sv
// SAP-2 accumulator, B register, ALU and W-bus driver.
// Build option SAP2_ALU_FLAGS_EN adds the {S, Z} flag register; without it flags reads 0.
module sap2_acc_alu_breg
  import sap2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [DATA_W-1:0] tmp_in,
  input  logic              nLa,
  input  logic              Ea,
  input  logic              nLb,
  input  logic              Eb,
  input  logic [3:0]        Sel,
  input  logic              Eu,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [DATA_W-1:0] acc_q,
  output logic [1:0]        flags
);

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] alu_r;
  logic              alu_s, alu_z;
  logic [1:0]        flags_d;

  sap2_alu #(.W(DATA_W)) u_alu (
    .a_i   (a_q),
    .t_i   (tmp_in),
    .sel_i (Sel),
    .r_o   (alu_r),
    .s_o   (alu_s),
    .z_o   (alu_z)
  );

  assign a_d = nLa ? a_q : bus_in;
  assign b_d = nLb ? b_q : bus_in;

  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_S] = alu_s;
    flags_d[FLAG_Z] = alu_z;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values; this is what lets A take the looped-back ALU result.
    if (CLR) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

`ifdef SAP2_ALU_FLAGS_EN
  logic [1:0] flags_q;

  // Flags capture the same pre-edge R that may be loaded into A.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)     flags_q <= '0;
    else if (Eu) flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^flags_d;
  assign flags        = 2'b00;
`endif

  // Fixed priority Eu > Ea > Eb keeps the bus deterministic on upstream errors.
  always_comb begin
    bus_out = '0;
    if (Eu)      bus_out = alu_r;
    else if (Ea) bus_out = a_q;
    else if (Eb) bus_out = b_q;
  end

  assign bus_oe = Ea | Eb | Eu;
  assign acc_q  = a_q;

endmodule

// File: tb/tb_sap2_acc_alu_breg.sv
// Scoreboard bench for sap2_acc_alu_breg: directed steps push hand-computed
// expectations; a negedge monitor pops and compares them against the DUT.
module tb_sap2_acc_alu_breg;
  import sap2_pkg::*;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [7:0] bus_in, bus_drv, tmp_in;
  logic       nLa, Ea, nLb, Eb, Eu, loop;
  logic [3:0] Sel;
  logic [7:0] bus_out, acc_q;
  logic       bus_oe;
  logic [1:0] flags;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [7:0] bus;
    logic       oe;
    logic [7:0] acc;
    logic [1:0] fl;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  assign bus_in = loop ? bus_out : bus_drv;

  sap2_acc_alu_breg dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .bus_in  (bus_in),
    .tmp_in  (tmp_in),
    .nLa     (nLa),
    .Ea      (Ea),
    .nLb     (nLb),
    .Eb      (Eb),
    .Sel     (Sel),
    .Eu      (Eu),
    .bus_out (bus_out),
    .bus_oe  (bus_oe),
    .acc_q   (acc_q),
    .flags   (flags)
  );

  function automatic logic [1:0] ef(input logic [1:0] f);
`ifdef SAP2_ALU_FLAGS_EN
    return f;
`else
    return 2'b00;
`endif
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare all expectations queued for the current cycle.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".bus_out"}, bus_out, e.bus);
      check({e.name, ".bus_oe"}, {7'd0, bus_oe}, {7'd0, e.oe});
      check({e.name, ".acc_q"}, acc_q, e.acc);
      check({e.name, ".flags"}, {6'd0, flags}, {6'd0, ef(e.fl)});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input string nm, input logic nla, input logic ea, input logic nlb,
                      input logic eb, input logic eu, input logic [3:0] sel,
                      input logic [7:0] bin, input logic [7:0] tin,
                      input logic [7:0] e_bus, input logic [7:0] e_acc, input logic [1:0] e_fl);
    exp_t e;
    nLa = nla; Ea = ea; nLb = nlb; Eb = eb; Eu = eu;
    Sel = sel; bus_drv = bin; tmp_in = tin;
    e.name = nm; e.bus = e_bus; e.oe = ea | eb | eu; e.acc = e_acc; e.fl = e_fl;
    sb.push_back(e);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR = 1'b1; loop = 1'b0;
    nLa = 1'b1; Ea = 1'b0; nLb = 1'b1; Eb = 1'b0; Eu = 1'b0;
    Sel = 4'h0; bus_drv = 8'h00; tmp_in = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    //    name         nLa  Ea  nLb  Eb  Eu  Sel        bus_in tmp    bus    acc    flags
    step("rst",        1,   0,  1,   0,  0,  ALU_ADD,   8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    CLR = 1'b0;
    step("ld_a_3c",    0,   0,  1,   0,  0,  ALU_ADD,   8'h3C, 8'h00, 8'h00, 8'h00, 2'b00);
    step("rd_a",       1,   1,  1,   0,  0,  ALU_ADD,   8'h00, 8'h00, 8'h3C, 8'h3C, 2'b00);
    step("ld_a_f0",    0,   0,  1,   0,  0,  ALU_ADD,   8'hF0, 8'h00, 8'h00, 8'h3C, 2'b00);
    step("add_wrap",   1,   0,  1,   0,  1,  ALU_ADD,   8'h00, 8'h20, 8'h10, 8'hF0, 2'b00);
    step("ld_a_20",    0,   0,  1,   0,  0,  ALU_ADD,   8'h20, 8'h00, 8'h00, 8'hF0, 2'b00);
    step("sub_zero",   1,   0,  1,   0,  1,  ALU_SUB,   8'h00, 8'h20, 8'h00, 8'h20, 2'b00);
    step("ld_a_10",    0,   0,  1,   0,  0,  ALU_ADD,   8'h10, 8'h00, 8'h00, 8'h20, 2'b01);
    step("sub_neg",    1,   0,  1,   0,  1,  ALU_SUB,   8'h00, 8'h20, 8'hF0, 8'h10, 2'b01);
    step("ld_a_81",    0,   0,  1,   0,  0,  ALU_ADD,   8'h81, 8'h00, 8'h00, 8'h10, 2'b10);
    step("and",        1,   0,  1,   0,  1,  ALU_AND,   8'h00, 8'h0F, 8'h01, 8'h81, 2'b10);
    step("or",         1,   0,  1,   0,  1,  ALU_OR,    8'h00, 8'h0F, 8'h8F, 8'h81, 2'b00);
    step("xor",        1,   0,  1,   0,  1,  ALU_XOR,   8'h00, 8'h0F, 8'h8E, 8'h81, 2'b10);
    step("cma",        1,   0,  1,   0,  1,  ALU_CMA,   8'h00, 8'h0F, 8'h7E, 8'h81, 2'b10);
    step("ral",        1,   0,  1,   0,  1,  ALU_RAL,   8'h00, 8'h0F, 8'h03, 8'h81, 2'b00);
    step("rar",        1,   0,  1,   0,  1,  ALU_RAR,   8'h00, 8'h0F, 8'hC0, 8'h81, 2'b00);
    step("inc_wrap",   1,   0,  1,   0,  1,  ALU_INC,   8'h00, 8'hFF, 8'h00, 8'h81, 2'b10);
    step("dec_wrap",   1,   0,  1,   0,  1,  ALU_DEC,   8'h00, 8'h00, 8'hFF, 8'h81, 2'b01);
    step("pass_a",     1,   0,  1,   0,  1,  ALU_PASSA, 8'h00, 8'h5A, 8'h81, 8'h81, 2'b10);
    step("pass_t",     1,   0,  1,   0,  1,  ALU_PASST, 8'h00, 8'h5A, 8'h5A, 8'h81, 2'b10);
    step("sel_c",      1,   0,  1,   0,  1,  4'hC,      8'h00, 8'h5A, 8'h00, 8'h81, 2'b00);
    step("sel_f",      1,   0,  1,   0,  1,  4'hF,      8'h00, 8'h5A, 8'h00, 8'h81, 2'b01);
    step("ld_a_05",    0,   0,  1,   0,  0,  ALU_ADD,   8'h05, 8'h00, 8'h00, 8'h81, 2'b01);
    loop = 1'b1;
    step("loopback",   0,   0,  1,   0,  1,  ALU_ADD,   8'h00, 8'h03, 8'h08, 8'h05, 2'b01);
    loop = 1'b0;
    step("nla_ea",     0,   1,  1,   0,  0,  ALU_ADD,   8'h3C, 8'h00, 8'h08, 8'h08, 2'b00);
    step("ld_b_aa",    1,   0,  0,   0,  0,  ALU_ADD,   8'hAA, 8'h00, 8'h00, 8'h3C, 2'b00);
    step("rd_b",       1,   0,  1,   1,  0,  ALU_ADD,   8'h00, 8'h00, 8'hAA, 8'h3C, 2'b00);
    step("ld_a_11",    0,   0,  1,   0,  0,  ALU_ADD,   8'h11, 8'h00, 8'h00, 8'h3C, 2'b00);
    step("prio_ea_eb", 1,   1,  1,   1,  0,  ALU_ADD,   8'h00, 8'h00, 8'h11, 8'h11, 2'b00);
    step("prio_eu",    1,   1,  1,   1,  1,  ALU_PASST, 8'h00, 8'h77, 8'h77, 8'h11, 2'b00);
    step("idle",       1,   0,  1,   0,  0,  ALU_ADD,   8'h00, 8'h00, 8'h00, 8'h11, 2'b00);
    step("pass_t_80",  1,   0,  1,   0,  1,  ALU_PASST, 8'h00, 8'h80, 8'h80, 8'h11, 2'b00);
    step("pre_clr",    1,   0,  1,   0,  0,  ALU_ADD,   8'h00, 8'h00, 8'h00, 8'h11, 2'b10);
    CLR = 1'b1;
    step("clr_async",  0,   0,  1,   1,  0,  ALU_ADD,   8'h99, 8'h00, 8'h00, 8'h00, 2'b00);
    step("clr_hold",   0,   0,  0,   1,  0,  ALU_ADD,   8'h99, 8'h00, 8'h00, 8'h00, 2'b00);
    CLR = 1'b0;
    step("ld_a_42",    0,   0,  1,   0,  0,  ALU_ADD,   8'h42, 8'h00, 8'h00, 8'h00, 2'b00);
    step("rd_a_42",    1,   1,  1,   0,  0,  ALU_ADD,   8'h00, 8'h00, 8'h42, 8'h42, 2'b00);

    @(negedge CLK);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
